// File: rtl/cordic_pkg.sv
// Shared constants for the handshaked CORDIC pipeline: arctangent table, gain table
// and the round/saturate helper used by the correction stage.
package cordic_pkg;

  localparam int unsigned TABLE_FRAC_WIDTH = 20;
  localparam int unsigned MAX_ITERATIONS   = 16;

  // atan(2^-i) in degrees, Q12.20
  localparam logic signed [31:0] ATAN_TABLE [0:MAX_ITERATIONS-1] = '{
    32'sd47185920, 32'sd27855475, 32'sd14718068, 32'sd7471121,
    32'sd3750058,  32'sd1876857,  32'sd938658,   32'sd469357,
    32'sd234682,   32'sd117342,   32'sd58671,    32'sd29335,
    32'sd14668,    32'sd7334,     32'sd3667,     32'sd1833
  };

  // Product of 1/sqrt(1+2^-2i) over the first n stages, unsigned 0.20
  localparam logic [19:0] CORDIC_GAIN [4:MAX_ITERATIONS] = '{
    20'd638409, 20'd637165, 20'd636854, 20'd636777, 20'd636757,
    20'd636752, 20'd636751, 20'd636751, 20'd636751, 20'd636751,
    20'd636751, 20'd636751, 20'd636751
  };

  // Move a fixed-point value between fraction widths (truncating when narrowing).
  function automatic logic signed [63:0] rescale(input logic signed [63:0] value,
                                                 input int unsigned from_frac,
                                                 input int unsigned to_frac);
    if (to_frac >= from_frac) return value <<< (to_frac - from_frac);
    return value >>> (from_frac - to_frac);
  endfunction

  // Drop `shift` fraction bits with round-half-up, then clamp to a signed `width`-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] value,
                                                   input int unsigned shift,
                                                   input int unsigned width);
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    if (shift == 0) rounded = value;
    else            rounded = (value + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (rounded > max_v)      return max_v;
    else if (rounded < min_v) return min_v;
    return rounded;
  endfunction

endpackage

// File: rtl/cordic_pipeline_hs_stage.sv
// One CORDIC micro-rotation with a registered result; holds while advance is low.
module cordic_stage #(
  parameter int unsigned             WIDTH      = 32,
  parameter int unsigned             FLIP_WIDTH = 2,
  parameter int unsigned             SHIFT      = 0,
  parameter logic signed [WIDTH-1:0] ANGLE      = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         advance,
  input  logic                         valid,
  input  logic                         mode,
  input  logic        [FLIP_WIDTH-1:0] flip,
  input  logic signed [WIDTH-1:0]      x,
  input  logic signed [WIDTH-1:0]      y,
  input  logic signed [WIDTH-1:0]      z,
  input  logic signed [WIDTH-1:0]      target,
  output logic                         valid_q,
  output logic                         mode_q,
  output logic        [FLIP_WIDTH-1:0] flip_q,
  output logic signed [WIDTH-1:0]      x_q,
  output logic signed [WIDTH-1:0]      y_q,
  output logic signed [WIDTH-1:0]      z_q,
  output logic signed [WIDTH-1:0]      target_q
);

  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;
  logic                    y_pos;
  logic                    dir;
  logic                    z_add;

  assign x_sh  = x >>> SHIFT;
  assign y_sh  = y >>> SHIFT;
  assign y_pos = !y[WIDTH-1] && (y != '0);
  // dir=1 rotates clockwise (x += y, y -= x); vectoring accumulates angle, rotation consumes it
  assign dir   = mode ? y_pos : (z > target);
  assign z_add = mode ? dir : !dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
      flip_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      target_q <= '0;
    end else if (advance) begin
      valid_q  <= valid;
      mode_q   <= mode;
      flip_q   <= flip;
      x_q      <= dir ? (x + y_sh) : (x - y_sh);
      y_q      <= dir ? (y - x_sh) : (y + x_sh);
      z_q      <= z_add ? (z + ANGLE) : (z - ANGLE);
      target_q <= target;
    end
  end

endmodule

// File: rtl/cordic_pipeline_hs.sv
// Ready/valid CORDIC core: ITERATION_NUMBER micro-rotation stages plus a registered
// gain-correction/saturation stage, all advancing together under a global stall.
module cordic_pipeline_hs
  import cordic_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH               = 16,
  parameter int unsigned INPUT_INT_WIDTH           = 7,
  parameter int unsigned INPUT_FRAC_WIDTH          = 8,
  parameter int unsigned OUTPUT_WIDTH              = 16,
  parameter int unsigned OUTPUT_INT_WIDTH          = 7,
  parameter int unsigned OUTPUT_FRAC_WIDTH         = 8,
  parameter int unsigned ITERATION_NUMBER          = 14,
  parameter int unsigned ITERATION_WORD_WIDTH      = 32,
  parameter int unsigned ITERATION_WORD_INT_WIDTH  = 12,
  parameter int unsigned ITERATION_WORD_FRAC_WIDTH = 20,
  parameter int unsigned FLIP_FLAG_WIDTH           = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [INPUT_WIDTH-1:0]  degree_in,
  input  logic signed [INPUT_WIDTH-1:0]  x_in,
  input  logic signed [INPUT_WIDTH-1:0]  y_in,
  input  logic [FLIP_FLAG_WIDTH-1:0]     flip_in,
  input  logic                           arctan_en_in,
  input  logic                           valid_in,
  output logic                           ready_in,
  output logic signed [OUTPUT_WIDTH-1:0] degree_out,
  output logic signed [OUTPUT_WIDTH-1:0] x_out,
  output logic signed [OUTPUT_WIDTH-1:0] y_out,
  output logic [FLIP_FLAG_WIDTH-1:0]     flip_out,
  output logic                           arctan_en_out,
  output logic                           valid_out,
  input  logic                           ready_out
);

  localparam int unsigned IW          = ITERATION_WORD_WIDTH;
  localparam int unsigned FW          = FLIP_FLAG_WIDTH;
  localparam int unsigned N           = ITERATION_NUMBER;
  localparam int unsigned ANGLE_SHIFT = ITERATION_WORD_FRAC_WIDTH - OUTPUT_FRAC_WIDTH;
  localparam int unsigned PROD_SHIFT  = TABLE_FRAC_WIDTH + ANGLE_SHIFT;
  localparam logic [19:0] GAIN        = CORDIC_GAIN[N];
  localparam logic signed [IW-1:0] ONE = IW'(64'sd1 <<< ITERATION_WORD_FRAC_WIDTH);

  function automatic logic signed [IW-1:0] widen(input logic signed [INPUT_WIDTH-1:0] v);
    return IW'(rescale(64'(v), INPUT_FRAC_WIDTH, ITERATION_WORD_FRAC_WIDTH));
  endfunction

  logic                    advance;
  logic                    valid_s  [N+1];
  logic                    mode_s   [N+1];
  logic [FW-1:0]           flip_s   [N+1];
  logic signed [IW-1:0]    x_s      [N+1];
  logic signed [IW-1:0]    y_s      [N+1];
  logic signed [IW-1:0]    z_s      [N+1];
  logic signed [IW-1:0]    t_s      [N+1];
  logic signed [2*IW-1:0]  x_prod;
  logic signed [2*IW-1:0]  y_prod;

  assign advance  = !valid_out || ready_out;
  assign ready_in = advance;

  // Stage-0 seed: unit vector for rotation, the operand pair for vectoring
  assign valid_s[0] = valid_in;
  assign mode_s[0]  = arctan_en_in;
  assign flip_s[0]  = flip_in;
  assign x_s[0]     = arctan_en_in ? widen(x_in) : ONE;
  assign y_s[0]     = arctan_en_in ? widen(y_in) : '0;
  assign z_s[0]     = '0;
  assign t_s[0]     = widen(degree_in);

  for (genvar i = 0; i < N; i++) begin : g_stage
    cordic_stage #(
      .WIDTH      (IW),
      .FLIP_WIDTH (FW),
      .SHIFT      (i),
      .ANGLE      (IW'(rescale(64'(ATAN_TABLE[i]), TABLE_FRAC_WIDTH, ITERATION_WORD_FRAC_WIDTH)))
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .advance  (advance),
      .valid    (valid_s[i]),
      .mode     (mode_s[i]),
      .flip     (flip_s[i]),
      .x        (x_s[i]),
      .y        (y_s[i]),
      .z        (z_s[i]),
      .target   (t_s[i]),
      .valid_q  (valid_s[i+1]),
      .mode_q   (mode_s[i+1]),
      .flip_q   (flip_s[i+1]),
      .x_q      (x_s[i+1]),
      .y_q      (y_s[i+1]),
      .z_q      (z_s[i+1]),
      .target_q (t_s[i+1])
    );
  end

  assign x_prod = (2*IW)'(x_s[N]) * (2*IW)'($signed({1'b0, GAIN}));
  assign y_prod = (2*IW)'(y_s[N]) * (2*IW)'($signed({1'b0, GAIN}));

  // Gain correction, rounding and saturation into the output format
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out     <= 1'b0;
      arctan_en_out <= 1'b0;
      flip_out      <= '0;
      x_out         <= '0;
      y_out         <= '0;
      degree_out    <= '0;
    end else if (advance) begin
      valid_out     <= valid_s[N];
      arctan_en_out <= mode_s[N];
      flip_out      <= flip_s[N];
      x_out         <= OUTPUT_WIDTH'(sat_round(64'(x_prod), PROD_SHIFT, OUTPUT_WIDTH));
      y_out         <= OUTPUT_WIDTH'(sat_round(64'(y_prod), PROD_SHIFT, OUTPUT_WIDTH));
      degree_out    <= OUTPUT_WIDTH'(sat_round(64'(z_s[N]), ANGLE_SHIFT, OUTPUT_WIDTH));
    end
  end

endmodule

// File: tb/tb_cordic_pipeline_hs.sv
// Directed bench for cordic_pipeline_hs: floating-point reference model feeding
// an in-order scoreboard, with stall, reset and saturation scenarios.
module tb_cordic_pipeline_hs;

  logic               clk;
  logic               reset;
  logic signed [15:0] degree_in, x_in, y_in;
  logic        [1:0]  flip_in;
  logic               arctan_en_in, valid_in, ready_in;
  logic signed [15:0] degree_out, x_out, y_out;
  logic        [1:0]  flip_out;
  logic               arctan_en_out, valid_out, ready_out;

  typedef struct {
    int         x;
    int         y;
    int         d;
    int         tx;
    int         ty;
    int         td;
    logic [1:0] flip;
    logic       mode;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  logic rand_ready;

  cordic_pipeline_hs dut (
    .clk           (clk),
    .reset         (reset),
    .degree_in     (degree_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .flip_in       (flip_in),
    .arctan_en_in  (arctan_en_in),
    .valid_in      (valid_in),
    .ready_in      (ready_in),
    .degree_out    (degree_out),
    .x_out         (x_out),
    .y_out         (y_out),
    .flip_out      (flip_out),
    .arctan_en_out (arctan_en_out),
    .valid_out     (valid_out),
    .ready_out     (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sat16(input real r);
    if (r >= 32767.0)  return 32767;
    if (r <= -32768.0) return -32768;
    return int'(r);
  endfunction

  function automatic exp_t model(input logic mode, input int d, input int x, input int y,
                                 input logic [1:0] flip);
    real  pi;
    real  rad;
    real  mag;
    exp_t e;
    pi     = 3.14159265358979;
    e.flip = flip;
    e.mode = mode;
    e.tx   = 3;
    e.ty   = 3;
    e.td   = 3;
    if (!mode) begin
      rad = real'(d) / 256.0 * pi / 180.0;
      e.x = sat16($cos(rad) * 256.0);
      e.y = sat16($sin(rad) * 256.0);
      e.d = d;
    end else begin
      mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      e.x = sat16(mag);
      if (mag >= 32767.0) e.tx = 0;
      e.y = 0;
      if (mag > 16384.0) e.ty = 8;
      e.d = sat16($atan2(real'(y), real'(x)) * 180.0 / pi * 256.0);
    end
    return e;
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp, input int tol);
    vectors++;
    assert (iabs(obs - exp) <= tol) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // One clock: settle, score the output/input handshakes, then advance past the edge.
  task automatic cycle(output logic acc);
    exp_t e;
    if (rand_ready) ready_out = 1'($urandom_range(0, 1));
    #1;
    if (valid_out && ready_out) begin
      if (sb.size() == 0) begin
        check_int("spurious_valid_out", int'(valid_out), 0, 0);
      end else begin
        e = sb.pop_front();
        check_int("x_out",         int'(x_out),         e.x,         e.tx);
        check_int("y_out",         int'(y_out),         e.y,         e.ty);
        check_int("degree_out",    int'(degree_out),    e.d,         e.td);
        check_int("flip_out",      int'(flip_out),      int'(e.flip), 0);
        check_int("arctan_en_out", int'(arctan_en_out), int'(e.mode), 0);
      end
    end
    acc = valid_in && ready_in;
    if (acc) sb.push_back(model(arctan_en_in, int'(degree_in), int'(x_in), int'(y_in), flip_in));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic mode, input int d, input int x, input int y,
                      input logic [1:0] flip);
    logic acc;
    acc          = 1'b0;
    valid_in     = 1'b1;
    arctan_en_in = mode;
    degree_in    = 16'(d);
    x_in         = 16'(x);
    y_in         = 16'(y);
    flip_in      = flip;
    for (int k = 0; k < 50; k++) begin
      cycle(acc);
      if (acc) break;
    end
    if (!acc) check_int("accept_timeout", int'(acc), 1, 0);
  endtask

  task automatic send_random();
    logic m;
    m = 1'($urandom_range(0, 1));
    if (!m) send(1'b0, int'($urandom_range(0, 46080)) - 23040, 0, 0, 2'($urandom_range(0, 3)));
    else    send(1'b1, 0, int'($urandom_range(64, 8192)), int'($urandom_range(0, 16384)) - 8192,
                 2'($urandom_range(0, 3)));
  endtask

  task automatic drain();
    logic acc;
    valid_in = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      cycle(acc);
    end
    check_int("drain_empty", int'(sb.size()), 0, 0);
  endtask

  // Single sample through an empty pipe: latency, then scoreboard check.
  task automatic single(input logic mode, input int d, input int x, input int y,
                        input logic [1:0] flip);
    logic acc;
    int   lat;
    send(mode, d, x, y, flip);
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 40) begin
      cycle(acc);
      lat++;
    end
    check_int("latency", lat, 15, 0);
    drain();
  endtask

  task automatic stall_check();
    ready_out = 1'b0;
    valid_in  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_int("stall_ready_in",  int'(ready_in),  0, 0);
      check_int("stall_valid_out", int'(valid_out), 1, 0);
      if (sb.size() != 0) begin
        check_int("stall_x_out",    int'(x_out),      sb[0].x,        sb[0].tx);
        check_int("stall_deg_out",  int'(degree_out), sb[0].d,        sb[0].td);
        check_int("stall_flip_out", int'(flip_out),   int'(sb[0].flip), 0);
      end
      @(posedge clk);
      #1;
    end
    ready_out = 1'b1;
  endtask

  initial begin
    logic acc;
    vectors      = 0;
    miscompares  = 0;
    rand_ready   = 1'b0;
    reset        = 1'b1;
    valid_in     = 1'b0;
    ready_out    = 1'b0;
    arctan_en_in = 1'b0;
    degree_in    = '0;
    x_in         = '0;
    y_in         = '0;
    flip_in      = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_valid_out",  int'(valid_out),     0, 0);
    check_int("rst_ready_in",   int'(ready_in),      1, 0);
    check_int("rst_x_out",      int'(x_out),         0, 0);
    check_int("rst_y_out",      int'(y_out),         0, 0);
    check_int("rst_degree_out", int'(degree_out),    0, 0);
    check_int("rst_flip_out",   int'(flip_out),      0, 0);
    check_int("rst_mode_out",   int'(arctan_en_out), 0, 0);
    @(negedge clk);
    reset     = 1'b1;
    ready_out = 1'b1;
    @(posedge clk);
    #1;

    single(1'b0, 16'sh1E00, 0, 0, 2'b01);
    single(1'b1, 0, 256, 256, 2'b10);
    single(1'b1, 0, 32767, 32767, 2'b11);

    for (int i = 0; i < 100; i++) begin
      if (i == 60) stall_check();
      send_random();
    end
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) send_random();
    rand_ready = 1'b0;
    ready_out  = 1'b1;
    drain();

    for (int i = 0; i < 10; i++) send_random();
    valid_in  = 1'b0;
    ready_out = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_int("mid_rst_valid_out",  int'(valid_out),     0, 0);
    check_int("mid_rst_ready_in",   int'(ready_in),      1, 0);
    check_int("mid_rst_x_out",      int'(x_out),         0, 0);
    check_int("mid_rst_y_out",      int'(y_out),         0, 0);
    check_int("mid_rst_degree_out", int'(degree_out),    0, 0);
    check_int("mid_rst_flip_out",   int'(flip_out),      0, 0);
    check_int("mid_rst_mode_out",   int'(arctan_en_out), 0, 0);
    sb.delete();
    @(negedge clk);
    reset     = 1'b1;
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 30; k++) cycle(acc);
    check_int("post_rst_idle", int'(valid_out), 0, 0);

    single(1'b0, -45 * 256, 0, 0, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cordic_pipeline_hs.md
# cordic_pipeline_hs

Parametrised successor to the fixed 6-stage CORDIC pipeline: a ready/valid-handshaked CORDIC core with configurable iteration depth (default 14), word widths, and a registered gain-correction stage with output saturation. Each sample carries its own mode bit. Rotation mode produces cos/sin of `degree_in`. Vectoring (arctan) mode produces atan(y/x) in degrees and the gain-corrected magnitude. The block sits between the quadrant-flip pre-processor and the post-flip/output formatter. `flip` is carried through untouched.

## Interface
- `INPUT_WIDTH`, 16: input word width, signed Q(INPUT_INT_WIDTH).(INPUT_FRAC_WIDTH) plus sign.
- `INPUT_INT_WIDTH`, 7 / `INPUT_FRAC_WIDTH`, 8: input integer and fraction bits.
- `OUTPUT_WIDTH`, 16 / `OUTPUT_INT_WIDTH`, 7 / `OUTPUT_FRAC_WIDTH`, 8: output format, same conventions as the input.
- `ITERATION_NUMBER`, 14: number of micro-rotation stages, legal range 4..16.
- `ITERATION_WORD_WIDTH`, 32 / `ITERATION_WORD_INT_WIDTH`, 12 / `ITERATION_WORD_FRAC_WIDTH`, 20: internal datapath format.
- `FLIP_FLAG_WIDTH`, 2: width of the sideband flip tag.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `degree_in` / `x_in` / `y_in`  in  INPUT_WIDTH  signed operands.
- `flip_in`  in  FLIP_FLAG_WIDTH  sideband tag.
- `arctan_en_in`  in  1  1 = vectoring mode, 0 = rotation mode.
- `valid_in`  in  1  input sample present.
- `ready_in`  out  1  core accepts a sample this cycle.
- `degree_out` / `x_out` / `y_out`  out  OUTPUT_WIDTH  signed results.
- `flip_out`  out  FLIP_FLAG_WIDTH  tag of the sample at the output.
- `arctan_en_out`  out  1  mode of the sample at the output.
- `valid_out`  out  1  result present.
- `ready_out`  in  1  downstream accepts the result.

## Operation
- **Input widening:** each input is sign-extended and zero-padded into the internal format, with the binary point aligned to `ITERATION_WORD_FRAC_WIDTH`.
- **Stage-0 initialisation:**
  - Rotation: x = 1.0, y = 0, z_target = `degree_in`, z_acc = 0.
  - Vectoring: x = `x_in`, y = `y_in`, z_acc = 0.
- **Stage i (i = 0..ITERATION_NUMBER-1):**
  - Vectoring: if y > 0, then x += y>>>i, y -= x>>>i, z_acc += ATAN[i]; otherwise the opposite signs.
  - Rotation: if z_acc > z_target, then x += y>>>i, y -= x>>>i, z_acc -= ATAN[i]; otherwise the opposite signs.
  - All shifts are arithmetic. Both sides of each update use the previous-stage x/y.
- **Correction stage (registered):**
  - x and y are multiplied by `CORDIC_GAIN[ITERATION_NUMBER]` (unsigned 0.20 fraction) with a full 2·ITERATION_WORD_WIDTH product.
  - Result is shifted back by 20 bits, rounded half-up, then saturated to the signed OUTPUT range.
  - `degree_out` = z_acc rounded to OUTPUT_FRAC_WIDTH, saturated.
- **Valid input domain:**
  - |degree_in| ≤ 90.0.
  - Vectoring requires x_in ≥ 0.
  - Outside this domain the output is undefined but must still be a saturated value. It must never wrap.
- **Flow control:** global stall. `advance = !valid_out || ready_out`.
  - When `advance` = 1, every stage register (data plus valid bit) shifts by one.
  - When `advance` = 0, all stage registers hold.
- **Acceptance:** `ready_in = advance`. A sample is accepted when `valid_in && ready_in`.
  - Bubbles (valid = 0) propagate as stages. They are not collapsed.
- **Reset:** asynchronous assertion clears every valid bit, all data registers, and the mode and flip registers to 0.
  - All outputs read 0.
  - `ready_in` reads 1 (valid_out = 0).
  - In-flight samples are discarded.

## Timing
- Latency is ITERATION_NUMBER + 1 cycles from acceptance to `valid_out` (15 by default), with no stall.
- Throughput is one sample per cycle while `ready_out` = 1.
- While `valid_out && !ready_out`, all outputs are stable and `ready_in` = 0.
- `ready_in` is combinational from `ready_out` and `valid_out`. It is the only combinational in→out path.
- The first edge after reset is deasserted performs normal operation.

## Structure
- Package `cordic_pkg` holds:
  - `ATAN_TABLE[0..15]`: atan(2^-i) in degrees, Q12.20.
  - `CORDIC_GAIN[4..16]`: Π 1/√(1+2^-2i), 0.20 fraction.
  - Rounding/saturation function `sat_round`.
- Natural sub-module: `cordic_stage`, one micro-rotation with parameter `SHIFT` and an advance enable, instantiated by a generate loop.
- The correction/saturation stage stays in the top module.

## Test plan
- **Rotation:** degree_in = 30.0 (0x1E00), arctan_en_in = 0 → after 15 cycles x_out = 222 ±2, y_out = 128 ±2, degree_out = 0x1E00 ±3.
- **Vectoring:** x_in = y_in = 1.0 (256), arctan_en_in = 1 → degree_out = 11520 ±3, x_out = 362 ±2, y_out = 0 ±2.
- **Stream:** 100 back-to-back random in-domain samples with ready_out = 1 → one result per cycle in order, flip_out/arctan_en_out match each input, error ≤ 3 LSB against a floating-point model.
- **Backpressure:**
  - ready_out = 0 for 5 cycles mid-stream → ready_in = 0, outputs frozen, no sample lost or duplicated.
  - Resume → remaining order preserved.
- **Reset mid-operation:** reset asserted with 10 samples in flight → valid_out = 0 and all outputs 0 immediately (asynchronous), ready_in = 1, no stale result after release.
- **Saturation:** vectoring x_in = y_in = 0x7FFF → x_out = 0x7FFF (saturated, no wrap), degree_out = 11520 ±3.
